jtpopeye_dma: RTL and testbench

JTPOPEYE_DMA -- requirements
Module: jtpopeye_dma

---
 rtl/jtpopeye_dma.sv | 127 ++++++++++++
 tb/tb_jtpopeye_dma.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_dma.sv
// jtpopeye_dma
//   Copies LEN words from CPU RAM (starting at SBASE) into object RAM once
//   per vertical blank. The CPU bus is requested for the whole transfer.
//   Each word takes two cen ticks: ADDR presents src_addr, and WR writes it.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   cen              transfer pacing enable
//   VB_n             vertical blank (active low); its falling edge starts a copy
//   dma_en           gates transfer starts only
//   busak_n/busrq_n  CPU bus acknowledge / request (active low)
//   src_addr/src_din source read port
//   dst_addr/dst_dout/dst_we  destination write port
//   busy, done, abort         status; done and abort are one-clk pulses
//
// Optional feature
//   JTPOPEYE_DMA_ABORT_EN: the end of blank (VB_n rising) during REQ/ADDR/WR
//   cuts the transfer short. It is jumped to REL with an abort pulse.
//   Without the macro, the end of blank is ignored and abort stays 0.
module jtpopeye_dma #(
   parameter int           DW    = 8,
   parameter int           SAW   = 10,
   parameter int           DAW   = 8,
   parameter int           LEN   = 256,
   parameter [SAW-1:0]     SBASE = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cen,
   input  logic           VB_n,
   input  logic           dma_en,
   input  logic           busak_n,
   output logic           busrq_n,
   output logic [SAW-1:0] src_addr,
   input  logic [DW-1:0]  src_din,
   output logic [DAW-1:0] dst_addr,
   output logic [DW-1:0]  dst_dout,
   output logic           dst_we,
   output logic           busy,
   output logic           done,
   output logic           abort
);

   // One extra bit so that count can hold LEN itself.
   localparam int CW = $clog2(LEN) + 1;

   typedef enum logic [2:0] { IDLE, REQ, ADDR, WR, REL } state_t;

   state_t        st;
   logic          vb_q;
   logic [CW-1:0] count;
   logic          start, step, last, abort_ev;

   assign start = vb_q & ~VB_n;          // registered 1->0 on VB_n
   assign step  = cen & ~busak_n;        // bus loss freezes ADDR/WR
   assign last  = count == CW'(LEN-1);

`ifdef JTPOPEYE_DMA_ABORT_EN
   assign abort_ev = ~vb_q & VB_n & (st == REQ || st == ADDR || st == WR);
`else
   assign abort_ev = 1'b0;
   assign abort    = 1'b0;
`endif

   assign busy     = st != IDLE;
   assign src_addr = SBASE + SAW'(count);
   assign dst_addr = DAW'(count);
   // Strobe is qualified with rst_n so the reset edge never writes, and
   // with abort_ev so an aborted word is not written.
   assign dst_we   = rst_n & (st == WR) & step & ~abort_ev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= IDLE;
         vb_q     <= 1'b1;
         count    <= '0;
         busrq_n  <= 1'b1;
         done     <= 1'b0;
         dst_dout <= '0;
`ifdef JTPOPEYE_DMA_ABORT_EN
         abort    <= 1'b0;
`endif
      end else begin
         vb_q <= VB_n;
         done <= 1'b0;
`ifdef JTPOPEYE_DMA_ABORT_EN
         abort <= 1'b0;
`endif
         case (st)
            IDLE: if (start && dma_en) begin
               st      <= REQ;
               busrq_n <= 1'b0;
            end
            REQ: if (!busak_n) begin
               st    <= ADDR;
               count <= '0;
            end
            // Source data is captured while src_addr is stable. It is held
            // through WR, so a stall in WR keeps the same word.
            ADDR: if (step) begin
               st       <= WR;
               dst_dout <= src_din;
            end
            WR: if (step) begin
               count <= count + CW'(1);
               if (last) begin
                  st      <= REL;
                  busrq_n <= 1'b1;
                  done    <= 1'b1;
               end else
                  st <= ADDR;
            end
            REL: if (busak_n) st <= IDLE;
            default: st <= IDLE;
         endcase
`ifdef JTPOPEYE_DMA_ABORT_EN
         if (abort_ev) begin
            st      <= REL;
            busrq_n <= 1'b1;
            abort   <= 1'b1;
            done    <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// tb_jtpopeye_dma
//   Scoreboard bench. Each started transfer pushes its expected writes
//   (dst address, data, and source address). A negedge monitor pops an entry
//   on every dst_we. A small bus model grants the bus 3 clks after the
//   request, and can be told to withdraw it for a few clks.
module tb_jtpopeye_dma;

   localparam int       DW = 8, SAW = 10, DAW = 8, LEN = 4;
   localparam [SAW-1:0] SBASE = 10'h3FE;

   logic           clk = 1'b0;
   logic           rst_n, cen, VB_n, dma_en, busak_n;
   logic           busrq_n, dst_we, busy, done, abort;
   logic [SAW-1:0] src_addr;
   logic [DW-1:0]  src_din, dst_dout;
   logic [DAW-1:0] dst_addr;

   jtpopeye_dma #(.DW(DW), .SAW(SAW), .DAW(DAW), .LEN(LEN), .SBASE(SBASE)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB_n(VB_n), .dma_en(dma_en),
      .busak_n(busak_n), .busrq_n(busrq_n), .src_addr(src_addr),
      .src_din(src_din), .dst_addr(dst_addr), .dst_dout(dst_dout),
      .dst_we(dst_we), .busy(busy), .done(done), .abort(abort)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_f(input logic [SAW-1:0] a);
      return a[7:0] * 8'd7 + {6'd0, a[9:8]} + 8'h3;
   endfunction
   assign src_din = mem_f(src_addr);

   typedef struct { logic [DAW-1:0] a; logic [DW-1:0] d; logic [SAW-1:0] s; } exp_t;
   exp_t q[$];

   int total = 0, bad = 0;
   int nwr = 0, ndone = 0, nabort = 0, cyc = 0;
   int stall = 0, cen_mode = 0, dly = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.a = DAW'(i);
         e.s = SAW'(SBASE + SAW'(i));
         e.d = mem_f(e.s);
         q.push_back(e);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard monitor
   always @(negedge clk) begin
      if (dst_we) begin
         nwr++;
         if (q.size() == 0) chk("extra_wr", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("wr_addr", 32'(dst_addr), 32'(e.a));
            chk("wr_data", 32'(dst_dout), 32'(e.d));
            chk("src_addr", 32'(src_addr), 32'(e.s));
         end
      end
      if (done)  ndone++;
      if (abort) nabort++;
   end

   // CPU bus model and cen generator
   initial begin
      busak_n = 1'b1;
      cen     = 1'b1;
      forever begin
         @(posedge clk); #1;
         cen = cen_mode ? ~cen : 1'b1;
         if (busrq_n) begin busak_n = 1'b1; dly = 0; end
         else if (stall > 0) begin busak_n = 1'b1; stall--; end
         else if (dly < 3) dly++;
         else busak_n = 1'b0;
      end
   end

   task automatic start_xfer();
      @(posedge clk); #2 VB_n = 1'b0;
      @(posedge clk); #2;
      chk("rq_low", busrq_n, 0);
      chk("busy_hi", busy, 1);
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin @(negedge clk); t++; end while (busy && t < 400);
      chk("idle_timeout", busy, 0);
      chk("rq_idle", busrq_n, 1);
      VB_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int d0, a0, c0, c1, t;
      rst_n = 1'b0; VB_n = 1'b1; dma_en = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busrq", busrq_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", dst_we, 0);
      chk("rst_done", done, 0);
      chk("rst_abort", abort, 0);
      chk("rst_src", 32'(src_addr), 32'(SBASE));
      chk("rst_dst", 32'(dst_addr), 0);
      chk("rst_dout", 32'(dst_dout), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // basic transfer with address wrap and latency
      d0 = ndone; push_exp(LEN); start_xfer();
      t = 0;
      do begin @(negedge clk); t++; end while (!dst_we && t < 100);
      chk("first_wr_to", dst_we, 1);
      c0 = cyc;
      t = 0;
      do begin @(negedge clk); t++; end while (!done && t < 100);
      chk("done_to", done, 1);
      c1 = cyc;
      chk("latency", 32'(c1 - c0), 32'(2*LEN-1));
      chk("rq_at_done", busrq_n, 1);
      wait_idle();
      chk("t1_done", 32'(ndone - d0), 1);
      chk("t1_q", 32'(q.size()), 0);

      // second VB_n fall while busy is dropped
      d0 = ndone; push_exp(LEN); start_xfer();
`ifndef JTPOPEYE_DMA_ABORT_EN
      @(posedge clk); #2 VB_n = 1'b1;
      @(posedge clk); #2 VB_n = 1'b0;
`endif
      wait_idle();
      chk("t2_done", 32'(ndone - d0), 1);
      chk("t2_q", 32'(q.size()), 0);

      // VB_n fall with dma_en low: nothing starts
      dma_en = 1'b0;
      @(posedge clk); #2 VB_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("noen_rq", busrq_n, 1);
      end
      chk("noen_busy", busy, 0);
      VB_n = 1'b1; dma_en = 1'b1;
      repeat (3) @(negedge clk);

      // bus withdrawn for 5 clks after word 1
      d0 = ndone; push_exp(LEN); start_xfer();
      t = 0;
      while (nwr % LEN != 2 && t < 100) begin @(negedge clk); t++; end
      stall = 5;
      t = 0;
      do begin @(negedge clk); t++; end while (busak_n == 1'b0 && t < 20);
      chk("stall_seen", busak_n, 1);
      while (busak_n && t < 40) begin
         chk("stall_we", dst_we, 0);
         @(negedge clk); t++;
      end
      wait_idle();
      chk("t4_done", 32'(ndone - d0), 1);
      chk("t4_q", 32'(q.size()), 0);

      // cen at half rate
      cen_mode = 1;
      d0 = ndone; push_exp(LEN); start_xfer();
      wait_idle();
      cen_mode = 0;
      chk("t5_done", 32'(ndone - d0), 1);
      chk("t5_q", 32'(q.size()), 0);

      // end of blank after word 1
      d0 = ndone; a0 = nabort;
`ifdef JTPOPEYE_DMA_ABORT_EN
      push_exp(2);
`else
      push_exp(LEN);
`endif
      start_xfer();
      t = 0;
      while (nwr % LEN != 2 && t < 100) begin @(negedge clk); t++; end
      @(posedge clk); #2 VB_n = 1'b1;
      wait_idle();
`ifdef JTPOPEYE_DMA_ABORT_EN
      chk("ab_abort", 32'(nabort - a0), 1);
      chk("ab_done", 32'(ndone - d0), 0);
`else
      chk("ab_abort", 32'(nabort - a0), 0);
      chk("ab_done", 32'(ndone - d0), 1);
`endif
      chk("ab_q", 32'(q.size()), 0);
      nwr = 0;

      // reset during WR of word 2
      push_exp(2); start_xfer();
      t = 0;
      do begin @(posedge clk); #2; t++; end while (!(dst_we && dst_addr == 8'd2) && t < 100);
      chk("rst_wr_seen", dst_we, 1);
      rst_n = 1'b0; VB_n = 1'b1; dma_en = 1'b0;
      #1 chk("rst_edge_we", dst_we, 0);
      @(posedge clk); #2;
      chk("rst_after_rq", busrq_n, 1);
      chk("rst_after_busy", busy, 0);
      chk("rst_after_we", dst_we, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_q", 32'(q.size()), 0);
      chk("rst_nwr", 32'(nwr), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
